// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin owner arbitration and write sequencing for a
// shared W-bit register.
//
// Requesters raise req[i] to ask for ownership. In IDLE the first set request
// at or after the round-robin pointer is granted. The owner may then load the
// register with its wr_data slice while holding req. Dropping req releases the
// grant and moves the pointer past the owner. Consecutive grants are always
// separated by one IDLE cycle.
//
// Optional feature, compile macro DFF_ARB_TIMEOUT_EN: a watchdog revokes a
// grant that has been held for MAX_HOLD cycles and pulses timeout for one
// cycle. With the macro undefined, grants last until release and timeout is 0.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-low reset
//   req      [N]    ownership request per requester
//   wr_en    [N]    write strobe per requester (only the owner's is honoured)
//   wr_data  [N*W]  requester i data at [i*W +: W]
//   gnt      [N]    registered one-hot grant, zero when idle
//   q        [W]    shared register contents
//   busy            high while a grant is active
//   timeout         one-cycle pulse after a watchdog revocation
module dff_reg_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   wr_en,
  input  logic [N*W-1:0] wr_data,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           busy,
  output logic           timeout
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  // Elaboration-time parameter sanity checks.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("dff_reg_arbiter: N must be in 2..8");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("dff_reg_arbiter: MAX_HOLD must be at least 2");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [W-1:0]    q_q, q_d;
  logic [IdxW-1:0] owner_next;

`ifdef DFF_ARB_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD);
  // hold_q counts completed grant cycles; it reads MAX_HOLD-1 during the
  // MAX_HOLD-th cycle, whose closing edge revokes the grant.
  logic [HoldW-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;
`endif

  // Round-robin search: first set request starting at ptr_q, wrapping mod N.
  logic            found;
  logic [IdxW-1:0] pick;
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  // Pointer value that skips past the current owner.
  assign owner_next = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + IdxW'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    q_d     = q_q;
`ifdef DFF_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d     = StGrant;
          owner_d     = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
`ifdef DFF_ARB_TIMEOUT_EN
          hold_d = '0;
`endif
        end
      end
      StGrant: begin
        // The owner's write is accepted even in the cycle it loses the grant.
        if (wr_en[owner_q]) begin
          q_d = wr_data[owner_q*W +: W];
        end
        if (!req[owner_q]) begin
          state_d = StIdle;
          gnt_d   = '0;
          ptr_d   = owner_next;
`ifdef DFF_ARB_TIMEOUT_EN
        end else if (hold_q == HoldW'(MAX_HOLD - 1)) begin
          state_d   = StIdle;
          gnt_d     = '0;
          ptr_d     = owner_next;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HoldW'(1);
`endif
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      q_q     <= '0;
`ifdef DFF_ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
`ifdef DFF_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign q    = q_q;
  assign busy = |gnt_q;
`ifdef DFF_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dff_reg_arbiter.sv
module tb_dff_reg_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 4;
`ifdef DFF_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   wr_en;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           busy;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  dff_reg_arbiter #(
    .N        (N),
    .W        (W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .gnt     (gnt),
    .q       (q),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the register, how many cycles the grant has
  // been visible, where the next search starts, and the register value.
  int          m_owner = -1;
  int          m_held  = 0;
  int          m_ptr   = 0;
  logic [W-1:0] m_q    = '0;
  logic        m_to    = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_q     = '0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int i = 0; i < N; i++) begin
          if (m_owner < 0 && req[(m_ptr + i) % N]) begin
            m_owner = (m_ptr + i) % N;
            m_held  = 1;
          end
        end
      end else begin
        if (wr_en[m_owner]) m_q = wr_data[m_owner*W +: W];
        if (!req[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end else if (ToEn && m_held == MAX_HOLD) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_to    = 1'b1;
        end else begin
          m_held++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_gnt;
    exp_gnt = '0;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    check("model_gnt", 32'(gnt), 32'(exp_gnt));
    check("model_q", 32'(q), 32'(m_q));
    check("model_busy", 32'(busy), 32'(m_owner >= 0));
    check("model_timeout", 32'(timeout), 32'(m_to));
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b0;
    req     = 4'b1111;
    wr_en   = '0;
    wr_data = '0;

    // Reset held for two cycles with all requests up.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_q", 32'(q), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end
    rst = 1'b1;
    step();
    check("first_gnt", 32'(gnt), 32'h1);

    // Fairness: each owner drops req after one grant cycle; owner 3 releases
    // while only 0 and 3 request, so the pointer must wrap to 0.
    for (int k = 0; k < N; k++) begin
      logic [N-1:0] exp_g;
      exp_g = '0;
      exp_g[k] = 1'b1;
      check("rr_gnt", 32'(gnt), 32'(exp_g));
      req = (k == 3) ? 4'b0001 : (4'b1111 & ~exp_g);
      step();
      check("rr_idle", 32'(gnt), 32'h0);
      req = (k == 3) ? 4'b1001 : 4'b1111;
      step();
    end
    check("wrap_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    check("release_idle", 32'(busy), 32'h0);

    // Single owner write; non-owner strobe ignored.
    req = 4'b0100;
    step();
    check("wr_gnt", 32'(gnt), 32'h4);
    wr_en   = 4'b0101;
    wr_data = 32'h00A5_00FF;
    step();
    check("wr_q", 32'(q), 32'hA5);
    wr_en = '0;
    step();
    check("wr_hold_q", 32'(q), 32'hA5);
    check("wr_hold_gnt", 32'(gnt), 32'h4);

    // Reset mid-grant: owner 1 writes in the reset cycle, write is dropped.
    req = 4'b0010;
    step();
    check("mid_idle", 32'(gnt), 32'h0);
    step();
    check("mid_gnt", 32'(gnt), 32'h2);
    rst     = 1'b0;
    wr_en   = 4'b0010;
    wr_data = 32'h0000_3C00;
    check("mid_q_before", 32'(q), 32'hA5);
    step();
    check("mid_q_after", 32'(q), 32'h0);
    check("mid_gnt_after", 32'(gnt), 32'h0);
    rst   = 1'b1;
    wr_en = '0;
    req   = 4'b0001;

    // Watchdog: requester 0 never releases.
    step();
    if (ToEn) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        check("wd_gnt", 32'(gnt), 32'h1);
        check("wd_to_low", 32'(timeout), 32'h0);
        step();
      end
      check("wd_revoked", 32'(gnt), 32'h0);
      check("wd_pulse", 32'(timeout), 32'h1);
      step();
      check("wd_regrant", 32'(gnt), 32'h1);
      check("wd_pulse_end", 32'(timeout), 32'h0);
    end else begin
      for (int c = 0; c < 2 * MAX_HOLD; c++) begin
        check("nowd_gnt", 32'(gnt), 32'h1);
        check("nowd_to", 32'(timeout), 32'h0);
        step();
      end
    end
    req = '0;
    step();
    step();

    // Randomised traffic, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(99) != 0);
      for (int b = 0; b < N; b++) req[b] = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) req = '0;
      wr_en   = N'($urandom);
      wr_data = ($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
